// File: rtl/wordlock_ctrl.sv
// Multi-lane word-lock / bitslip controller; all lanes share one core clock and window counter.
// Define WORDLOCK_STATS_EN to build the per-lane lock-loss counters (tied to zero otherwise).
module wordlock_ctrl #(
  parameter int unsigned NUM_LN        = 4,
  parameter int unsigned WIN_LOG2      = 4,
  parameter int unsigned UNLOCK_THRESH = 8,
  parameter int unsigned FLUSH_WIN     = 1,
  parameter int unsigned LOCK_WIN      = 1,
  parameter int unsigned SLIP_MAX      = 40
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_LN-1:0]   lane_en_i,
  input  logic [NUM_LN-1:0]   force_relock_i,
  input  logic [NUM_LN-1:0]   err_fix_i,
  input  logic [NUM_LN-1:0]   err_fail_i,
  output logic [NUM_LN-1:0]   bitslip_o,
  output logic [NUM_LN-1:0]   wordlock_o,
  output logic [NUM_LN-1:0]   slip_exhaust_o,
  output logic [8*NUM_LN-1:0] slip_cnt_o,
  output logic [8*NUM_LN-1:0] lock_loss_cnt_o
);

  localparam int unsigned EW = WIN_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_OBSERVE = 2'd0,
    ST_SLIP    = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [WIN_LOG2-1:0] win_q;
  logic                win_end;
  logic [NUM_LN-1:0]   err_s;
  logic [EW-1:0]       err_cnt_q [NUM_LN];
  logic [EW-1:0]       run_cnt   [NUM_LN];
  logic [NUM_LN-1:0]   any_err_q;
  state_e              state_q   [NUM_LN];
  state_e              state_d   [NUM_LN];
  logic [3:0]          clean_q   [NUM_LN];
  logic [3:0]          clean_d   [NUM_LN];
  logic [3:0]          flush_q   [NUM_LN];
  logic [3:0]          flush_d   [NUM_LN];
  logic [7:0]          slip_cnt_q[NUM_LN];
  logic [NUM_LN-1:0]   slip_exh_q;
  logic [NUM_LN-1:0]   bitslip_q;
  logic [NUM_LN-1:0]   wordlock_q;

  assign win_end = (win_q == {WIN_LOG2{1'b1}});
  assign err_s   = err_fix_i | err_fail_i;

  // Shared free-running observation window counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= {WIN_LOG2{1'b0}};
    end else begin
      win_q <= win_q + {{(WIN_LOG2-1){1'b0}}, 1'b1};
    end
  end

  // Window error count including this cycle's error, saturating
  always_comb begin
    for (int l = 0; l < NUM_LN; l++) begin
      if (err_cnt_q[l] == {EW{1'b1}}) begin
        run_cnt[l] = err_cnt_q[l];
      end else begin
        run_cnt[l] = err_cnt_q[l] + {{(EW-1){1'b0}}, err_s[l]};
      end
    end
  end

  // Per-window error statistics, restarted after every window end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      any_err_q <= {NUM_LN{1'b0}};
      for (int l = 0; l < NUM_LN; l++) err_cnt_q[l] <= {EW{1'b0}};
    end else begin
      for (int l = 0; l < NUM_LN; l++) begin
        if (win_end) begin
          err_cnt_q[l] <= {EW{1'b0}};
          any_err_q[l] <= 1'b0;
        end else begin
          err_cnt_q[l] <= run_cnt[l];
          any_err_q[l] <= any_err_q[l] | err_s[l];
        end
      end
    end
  end

  // Per-lane next-state logic; lane enable beats relock, relock beats everything else
  always_comb begin
    for (int l = 0; l < NUM_LN; l++) begin
      state_d[l] = state_q[l];
      clean_d[l] = clean_q[l];
      flush_d[l] = flush_q[l];
      if (!lane_en_i[l]) begin
        state_d[l] = ST_OBSERVE;
        clean_d[l] = 4'd0;
        flush_d[l] = 4'd0;
      end else if (force_relock_i[l] && (state_q[l] != ST_SLIP)) begin
        state_d[l] = ST_SLIP;
        clean_d[l] = 4'd0;
      end else begin
        case (state_q[l])
          ST_OBSERVE: begin
            if (!win_end) begin
              state_d[l] = ST_OBSERVE;
            end else if (any_err_q[l] || err_s[l]) begin
              state_d[l] = ST_SLIP;
              clean_d[l] = 4'd0;
            end else if ((clean_q[l] + 4'd1) == 4'(LOCK_WIN)) begin
              state_d[l] = ST_LOCKED;
              clean_d[l] = 4'd0;
            end else begin
              clean_d[l] = clean_q[l] + 4'd1;
            end
          end
          ST_SLIP: begin
            state_d[l] = ST_FLUSH;
            flush_d[l] = 4'd0;
          end
          ST_FLUSH: begin
            if (!win_end) begin
              state_d[l] = ST_FLUSH;
            end else if ((flush_q[l] + 4'd1) == 4'(FLUSH_WIN)) begin
              state_d[l] = ST_OBSERVE;
              flush_d[l] = 4'd0;
            end else begin
              flush_d[l] = flush_q[l] + 4'd1;
            end
          end
          ST_LOCKED: begin
            // Dropping lock does not slip; OBSERVE decides at its next window end
            if (run_cnt[l] >= EW'(UNLOCK_THRESH)) begin
              state_d[l] = ST_OBSERVE;
            end else begin
              state_d[l] = ST_LOCKED;
            end
          end
          default: begin
            state_d[l] = ST_OBSERVE;
          end
        endcase
      end
    end
  end

  // Lane state, registered outputs and slip bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bitslip_q  <= {NUM_LN{1'b0}};
      wordlock_q <= {NUM_LN{1'b0}};
      slip_exh_q <= {NUM_LN{1'b0}};
      for (int l = 0; l < NUM_LN; l++) begin
        state_q[l]    <= ST_OBSERVE;
        clean_q[l]    <= 4'd0;
        flush_q[l]    <= 4'd0;
        slip_cnt_q[l] <= 8'd0;
      end
    end else begin
      for (int l = 0; l < NUM_LN; l++) begin
        state_q[l]    <= state_d[l];
        clean_q[l]    <= clean_d[l];
        flush_q[l]    <= flush_d[l];
        bitslip_q[l]  <= (state_d[l] == ST_SLIP);
        // Lock is reported one cycle after LOCKED is entered but drops on the same edge it is left
        wordlock_q[l] <= (state_d[l] == ST_LOCKED) && (state_q[l] == ST_LOCKED);
        if ((state_d[l] == ST_LOCKED) && (state_q[l] != ST_LOCKED)) begin
          slip_cnt_q[l] <= 8'd0;
          slip_exh_q[l] <= 1'b0;
        end else if ((state_d[l] == ST_SLIP) && (state_q[l] != ST_SLIP)) begin
          slip_cnt_q[l] <= sat_inc8(slip_cnt_q[l]);
          if (({1'b0, slip_cnt_q[l]} + 9'd1) >= 9'(SLIP_MAX)) begin
            slip_exh_q[l] <= 1'b1;
          end else begin
            slip_exh_q[l] <= slip_exh_q[l];
          end
        end else begin
          slip_cnt_q[l] <= slip_cnt_q[l];
          slip_exh_q[l] <= slip_exh_q[l];
        end
      end
    end
  end

`ifdef WORDLOCK_STATS_EN
  logic [7:0] lock_loss_q [NUM_LN];

  // Count every departure from LOCKED
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int l = 0; l < NUM_LN; l++) lock_loss_q[l] <= 8'd0;
    end else begin
      for (int l = 0; l < NUM_LN; l++) begin
        if ((state_q[l] == ST_LOCKED) && (state_d[l] != ST_LOCKED)) begin
          lock_loss_q[l] <= sat_inc8(lock_loss_q[l]);
        end else begin
          lock_loss_q[l] <= lock_loss_q[l];
        end
      end
    end
  end

  // Pack statistics output
  always_comb begin
    lock_loss_cnt_o = {(8*NUM_LN){1'b0}};
    for (int l = 0; l < NUM_LN; l++) lock_loss_cnt_o[8*l +: 8] = lock_loss_q[l];
  end
`else
  assign lock_loss_cnt_o = {(8*NUM_LN){1'b0}};
`endif

  assign bitslip_o      = bitslip_q;
  assign wordlock_o     = wordlock_q;
  assign slip_exhaust_o = slip_exh_q;

  // Pack per-lane slip counters
  always_comb begin
    slip_cnt_o = {(8*NUM_LN){1'b0}};
    for (int l = 0; l < NUM_LN; l++) slip_cnt_o[8*l +: 8] = slip_cnt_q[l];
  end

endmodule

// File: tb/tb_wordlock_ctrl.sv
// Self-checking bench for wordlock_ctrl: default instance plus a SLIP_MAX=3 instance on shared stimulus.
// A lane-level behavioural model is compared every cycle; literal expectations pin key timings.
module tb_wordlock_ctrl;

  localparam int NL = 4;
  localparam int W  = 16;
  localparam int THRESH = 8;
  localparam int FLUSH_W = 1;
  localparam int LOCK_W  = 1;
`ifdef WORDLOCK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int M_OBS = 0, M_SLIP = 1, M_FLUSH = 2, M_LOCK = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NL-1:0] en = '0, fr = '0, efix = '0, efail = '0;
  logic [NL-1:0] bs [2];
  logic [NL-1:0] wl [2];
  logic [NL-1:0] ex [2];
  logic [31:0]   sc [2];
  logic [31:0]   ll [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  wordlock_ctrl u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .lane_en_i(en), .force_relock_i(fr),
    .err_fix_i(efix), .err_fail_i(efail), .bitslip_o(bs[0]), .wordlock_o(wl[0]),
    .slip_exhaust_o(ex[0]), .slip_cnt_o(sc[0]), .lock_loss_cnt_o(ll[0])
  );

  wordlock_ctrl #(.SLIP_MAX(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .lane_en_i(en), .force_relock_i(fr),
    .err_fix_i(efix), .err_fail_i(efail), .bitslip_o(bs[1]), .wordlock_o(wl[1]),
    .slip_exhaust_o(ex[1]), .slip_cnt_o(sc[1]), .lock_loss_cnt_o(ll[1])
  );

  // Behavioural model state per (instance, lane)
  int m_mode [2][NL];
  int m_clean[2][NL];
  int m_flush[2][NL];
  int m_wcnt [2][NL];
  bit m_wany [2][NL];
  int m_sc   [2][NL];
  int m_ll   [2][NL];
  bit m_ex   [2][NL];
  bit m_bs   [2][NL];
  bit m_wl   [2][NL];
  int m_t;
  int smax [2] = '{40, 3};

  task automatic model_reset();
    m_t = 0;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++) begin
        m_mode[d][l] = M_OBS; m_clean[d][l] = 0; m_flush[d][l] = 0;
        m_wcnt[d][l] = 0; m_wany[d][l] = 0; m_sc[d][l] = 0; m_ll[d][l] = 0;
        m_ex[d][l] = 0; m_bs[d][l] = 0; m_wl[d][l] = 0;
      end
  endtask

  task automatic model_step();
    bit we;
    we = ((m_t % W) == W - 1);
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++) begin
        int e, nc, old, nw;
        bit na;
        e  = (efix[l] | efail[l]) ? 1 : 0;
        nc = m_wcnt[d][l] + e;
        na = m_wany[d][l] | (e != 0);
        old = m_mode[d][l];
        nw  = old;
        if (!en[l]) begin
          nw = M_OBS; m_clean[d][l] = 0; m_flush[d][l] = 0;
        end else if (fr[l] && old != M_SLIP) begin
          nw = M_SLIP; m_clean[d][l] = 0;
        end else if (old == M_SLIP) begin
          nw = M_FLUSH; m_flush[d][l] = 0;
        end else if (old == M_FLUSH) begin
          if (we) begin
            m_flush[d][l]++;
            if (m_flush[d][l] == FLUSH_W) begin nw = M_OBS; m_flush[d][l] = 0; end
          end
        end else if (old == M_LOCK) begin
          if (nc >= THRESH) nw = M_OBS;
        end else if (we) begin
          if (na) begin
            nw = M_SLIP; m_clean[d][l] = 0;
          end else begin
            m_clean[d][l]++;
            if (m_clean[d][l] == LOCK_W) begin nw = M_LOCK; m_clean[d][l] = 0; end
          end
        end
        if (nw == M_SLIP && old != M_SLIP) begin
          m_sc[d][l] = (m_sc[d][l] < 255) ? m_sc[d][l] + 1 : 255;
          if (m_sc[d][l] >= smax[d]) m_ex[d][l] = 1'b1;
        end
        if (nw == M_LOCK && old != M_LOCK) begin
          m_sc[d][l] = 0; m_ex[d][l] = 1'b0;
        end
        if (STATS && old == M_LOCK && nw != M_LOCK)
          m_ll[d][l] = (m_ll[d][l] < 255) ? m_ll[d][l] + 1 : 255;
        m_bs[d][l]   = (nw == M_SLIP);
        m_wl[d][l]   = (nw == M_LOCK) && (old == M_LOCK);
        m_wcnt[d][l] = we ? 0 : nc;
        m_wany[d][l] = we ? 1'b0 : na;
        m_mode[d][l] = nw;
      end
    m_t++;
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // Advance one clock: model follows the DUT edge, then move to mid-cycle
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    cyc++;
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        logic [NL-1:0] eb, ew, ee;
        logic [31:0] es, el;
        es = '0; el = '0;
        for (int l = 0; l < NL; l++) begin
          eb[l] = m_bs[d][l]; ew[l] = m_wl[d][l]; ee[l] = m_ex[d][l];
          es[8*l +: 8] = 8'(m_sc[d][l]);
          el[8*l +: 8] = 8'(m_ll[d][l]);
        end
        chk("bitslip", d, 32'(bs[d]), 32'(eb));
        chk("wordlock", d, 32'(wl[d]), 32'(ew));
        chk("slip_exhaust", d, 32'(ex[d]), 32'(ee));
        chk("slip_cnt", d, sc[d], es);
        chk("lock_loss_cnt", d, ll[d], el);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("lit_reset_wl", 0, 32'(wl[0]), 32'd0);
    chk("lit_reset_sc", 1, sc[1], 32'd0);
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 0; c <= 380; c++) begin
      en = (c >= 300 && c <= 310) ? 4'b0111 : 4'b1111;
      fr = 4'b0000;
      fr[3] = (c == 300 || c == 330 || c == 331);
      fr[1] = (c >= 368 && c <= 376 && (c % 2) == 0);
      efix = 4'b0000;
      efix[1] = (c <= 39);
      efix[2] = (c >= 176 && c <= 259);
      efail = 4'b0000;
      efail[0] = (c >= 96 && c <= 102) || (c >= 112 && c <= 119);
      if (c == 16) begin
        chk("lit_wl0_c16", 0, 32'(wl[0][0]), 32'd0);
        chk("lit_bs1_c16", 0, 32'(bs[0][1]), 32'd1);
      end
      if (c == 17) chk("lit_wl0_c17", 0, 32'(wl[0][0]), 32'd1);
      if (c == 48) begin
        chk("lit_bs1_c48", 0, 32'(bs[0][1]), 32'd1);
        chk("lit_sc1_c48", 0, 32'(sc[0][15:8]), 32'd2);
      end
      if (c == 80) chk("lit_sc1_c80", 0, 32'(sc[0][15:8]), 32'd0);
      if (c == 81) chk("lit_wl1_c81", 0, 32'(wl[0][1]), 32'd1);
      if (c == 112) chk("lit_wl0_7err", 0, 32'(wl[0][0]), 32'd1);
      if (c == 119) chk("lit_wl0_c119", 0, 32'(wl[0][0]), 32'd1);
      if (c == 120) begin
        chk("lit_wl0_8err", 0, 32'(wl[0][0]), 32'd0);
        chk("lit_ll0_c120", 0, 32'(ll[0][7:0]), 32'(STATS));
      end
      if (c == 128) chk("lit_bs0_c128", 0, 32'(bs[0][0]), 32'd1);
      if (c == 255) chk("lit_ex2_c255", 1, 32'(ex[1][2]), 32'd0);
      if (c == 256) begin
        chk("lit_ex2_c256", 1, 32'(ex[1][2]), 32'd1);
        chk("lit_bs2_c256", 1, 32'(bs[1][2]), 32'd1);
        chk("lit_ex2_dflt", 0, 32'(ex[0][2]), 32'd0);
      end
      if (c == 287) chk("lit_ex2_c287", 1, 32'(ex[1][2]), 32'd1);
      if (c == 288) chk("lit_ex2_c288", 1, 32'(ex[1][2]), 32'd0);
      if (c == 289) chk("lit_wl2_c289", 1, 32'(wl[1][2]), 32'd1);
      if (c == 301) begin
        chk("lit_wl3_c301", 0, 32'(wl[0][3]), 32'd0);
        chk("lit_bs3_c301", 0, 32'(bs[0][3]), 32'd0);
      end
      if (c == 321) chk("lit_wl3_c321", 0, 32'(wl[0][3]), 32'd1);
      if (c == 331) chk("lit_bs3_c331", 0, 32'(bs[0][3]), 32'd1);
      if (c == 332) chk("lit_bs3_c332", 0, 32'(bs[0][3]), 32'd0);
      if (c == 353) chk("lit_wl3_c353", 0, 32'(wl[0][3]), 32'd1);
      if (c == 380) chk("lit_sc1_c380", 0, 32'(sc[0][15:8]), 32'd5);
      if (c < 380) step();
    end
    // Asynchronous reset in the middle of FLUSH
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("lit_arst_bs", d, 32'(bs[d]), 32'd0);
      chk("lit_arst_wl", d, 32'(wl[d]), 32'd0);
      chk("lit_arst_ex", d, 32'(ex[d]), 32'd0);
      chk("lit_arst_sc", d, sc[d], 32'd0);
      chk("lit_arst_ll", d, ll[d], 32'd0);
    end
    model_reset();
    en = 4'b1111; fr = 4'b0000; efix = 4'b0000; efail = 4'b0000;
    repeat (3) step();
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c == 16) chk("lit_rr_wl1_c16", 0, 32'(wl[0][1]), 32'd0);
      if (c == 17) begin
        chk("lit_rr_wl_c17", 0, 32'(wl[0]), 32'hF);
        chk("lit_rr_sc_c17", 0, sc[0], 32'd0);
      end
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
